// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SERVE0 = 2'd1,
      ST_SERVE1 = 2'd2
   } state_t;

   localparam logic PORT_CORE = 1'b0;
   localparam logic PORT_LDR  = 1'b1;

endpackage

// File: rtl/arb_pick.sv
// Two-input request picker. Tie policy: round-robin against `last` when
// DMEM_ARB_RR_EN is defined, otherwise fixed priority to the core port.
module arb_pick
   import dmem_arb_pkg::*;
(
   input  logic req0,
   input  logic req1,
   input  logic last,
   output logic valid,
   output logic winner
);

`ifndef DMEM_ARB_RR_EN
   logic unused_last;
   assign unused_last = last;
`endif

   always_comb begin
      valid  = req0 | req1;
      winner = PORT_CORE;
      if (req0 && req1) begin
`ifdef DMEM_ARB_RR_EN
         winner = ~last;
`else
         winner = PORT_CORE;
`endif
      end else if (req1) begin
         winner = PORT_LDR;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data memory between the core (port 0) and loader (port 1) via an
// IDLE/SERVE0/SERVE1 grant FSM with locked port-1 bursts. Tie policy: DMEM_ARB_RR_EN.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W    = 64,
   parameter int DATA_W    = 64,
   parameter int MAX_BURST = 8
) (
   input  logic              Clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              ack0,
   output logic [DATA_W-1:0] rdata0,
   output logic              stall0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata1,
   input  logic              lock1,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_MemWrite,
   output logic              mem_MemRead,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int CNT_W = $clog2(MAX_BURST) + 1;
   localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(MAX_BURST);

   state_t           state;
   logic [CNT_W-1:0] burst_cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             last;
   logic             pick_valid;
   logic             pick_winner;

   arb_pick u_pick (
      .req0   (req0),
      .req1   (req1),
      .last   (last),
      .valid  (pick_valid),
      .winner (pick_winner)
   );

   assign cnt_nxt = burst_cnt + 1'b1;

   always_ff @(posedge Clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         burst_cnt <= '0;
         last      <= PORT_LDR;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pick_valid) begin
                  state <= (pick_winner == PORT_LDR) ? ST_SERVE1 : ST_SERVE0;
                  last  <= pick_winner;
               end
            end
            ST_SERVE0: state <= ST_IDLE;
            ST_SERVE1: begin
               // Idle cycles inside a locked tenure still consume burst budget.
               if (lock1 && (cnt_nxt < BURST_LIM)) begin
                  burst_cnt <= cnt_nxt;
               end else begin
                  state     <= ST_IDLE;
                  burst_cnt <= '0;
               end
            end
            default: begin
               state     <= ST_IDLE;
               burst_cnt <= '0;
            end
         endcase
      end
   end

   // Strobes and acks are gated by reset so no write can commit at a reset edge.
   always_comb begin
      ack0         = 1'b0;
      ack1         = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;
      mem_MemWrite = 1'b0;
      mem_MemRead  = 1'b0;
      case (state)
         ST_SERVE0: begin
            mem_addr  = addr0;
            mem_wdata = wdata0;
            if (req0 && !reset) begin
               ack0         = 1'b1;
               mem_MemWrite = we0;
               mem_MemRead  = ~we0;
            end
         end
         ST_SERVE1: begin
            mem_addr  = addr1;
            mem_wdata = wdata1;
            if (req1 && !reset) begin
               ack1         = 1'b1;
               mem_MemWrite = we1;
               mem_MemRead  = ~we1;
            end
         end
         default: ;
      endcase
      rdata0 = (ack0 && !we0) ? mem_rdata : '0;
      rdata1 = (ack1 && !we1) ? mem_rdata : '0;
      stall0 = req0 & ~ack0;
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural memory; tie expectations
// follow DMEM_ARB_RR_EN.
module tb_dmem_arbiter;

   logic        Clk = 1'b0;
   logic        reset;
   logic        req0, we0, ack0, stall0;
   logic [63:0] addr0, wdata0, rdata0;
   logic        req1, we1, ack1, lock1;
   logic [63:0] addr1, wdata1, rdata1;
   logic [63:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_MemWrite, mem_MemRead;
   logic [63:0] mem [0:255];

   int n_assert = 0;
   int n_fail   = 0;

   always #5 Clk = ~Clk;

   dmem_arbiter #(.ADDR_W(64), .DATA_W(64), .MAX_BURST(4)) dut (
      .Clk          (Clk),
      .reset        (reset),
      .req0         (req0),
      .we0          (we0),
      .addr0        (addr0),
      .wdata0       (wdata0),
      .ack0         (ack0),
      .rdata0       (rdata0),
      .stall0       (stall0),
      .req1         (req1),
      .we1          (we1),
      .addr1        (addr1),
      .wdata1       (wdata1),
      .ack1         (ack1),
      .rdata1       (rdata1),
      .lock1        (lock1),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_MemWrite (mem_MemWrite),
      .mem_MemRead  (mem_MemRead),
      .mem_rdata    (mem_rdata)
   );

   assign mem_rdata = mem[mem_addr[7:0]];

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      mem[8'h20] = 64'h55;
      mem[8'h30] = 64'h77;
      forever begin
         @(posedge Clk);
         if (mem_MemWrite === 1'b1) mem[mem_addr[7:0]] = mem_wdata;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1; lock1 = 1'b1;
      req0 = 1'b1; we0 = 1'b1; addr0 = 64'h30; wdata0 = 64'h1;
      req1 = 1'b1; we1 = 1'b1; addr1 = 64'h30; wdata1 = 64'h2;

      // Reset held three cycles with both requests up
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("rst_ack0", ack0, 1'b0);
         chk("rst_ack1", ack1, 1'b0);
         chk("rst_memwrite", mem_MemWrite, 1'b0);
         chk("rst_memread", mem_MemRead, 1'b0);
         chk("rst_rdata0", rdata0, 64'h0);
         chk("rst_rdata1", rdata1, 64'h0);
         @(negedge Clk);
      end
      reset = 1'b0; req0 = 1'b0; req1 = 1'b0; lock1 = 1'b0;
      #1;
      chk("idle_addr", mem_addr, 64'h0);
      chk("idle_stall0", stall0, 1'b0);
      chk("idle_memread", mem_MemRead, 1'b0);
      @(negedge Clk);

      // Core write 0x10 <- 0xDEAD
      req0 = 1'b1; we0 = 1'b1; addr0 = 64'h10; wdata0 = 64'hDEAD;
      #1;
      chk("wr_stall0", stall0, 1'b1);
      chk("wr_ack0_early", ack0, 1'b0);
      chk("wr_memwrite_early", mem_MemWrite, 1'b0);
      @(negedge Clk);
      #1;
      chk("wr_ack0", ack0, 1'b1);
      chk("wr_memwrite", mem_MemWrite, 1'b1);
      chk("wr_addr", mem_addr, 64'h10);
      chk("wr_wdata", mem_wdata, 64'hDEAD);
      chk("wr_stall0_done", stall0, 1'b0);
      @(negedge Clk);

      // Loader read of preloaded 0x20
      req0 = 1'b0; req1 = 1'b1; we1 = 1'b0; addr1 = 64'h20;
      #1;
      chk("rd1_ack1_early", ack1, 1'b0);
      chk("rd1_idle_addr", mem_addr, 64'h0);
      @(negedge Clk);
      #1;
      chk("rd1_ack1", ack1, 1'b1);
      chk("rd1_memread", mem_MemRead, 1'b1);
      chk("rd1_rdata1", rdata1, 64'h55);
      chk("rd1_rdata0", rdata0, 64'h0);
      chk("rd1_addr", mem_addr, 64'h20);
      @(negedge Clk);

      // Core read-back of 0x10
      req1 = 1'b0; req0 = 1'b1; we0 = 1'b0; addr0 = 64'h10;
      #1;
      chk("rb_ack0_early", ack0, 1'b0);
      @(negedge Clk);
      #1;
      chk("rb_ack0", ack0, 1'b1);
      chk("rb_rdata0", rdata0, 64'hDEAD);
      @(negedge Clk);

      // Fresh reset so `last` points at port 1, then two back-to-back ties
      req0 = 1'b0; reset = 1'b1;
      @(negedge Clk);
      reset = 1'b0;
      req0 = 1'b1; we0 = 1'b0; addr0 = 64'h10;
      req1 = 1'b1; we1 = 1'b0; addr1 = 64'h20;
      #1;
      chk("tie1_idle_ack0", ack0, 1'b0);
      chk("tie1_idle_ack1", ack1, 1'b0);
      @(negedge Clk);
      #1;
      chk("tie1_ack0", ack0, 1'b1);
      chk("tie1_ack1", ack1, 1'b0);
      chk("tie1_addr", mem_addr, 64'h10);
      @(negedge Clk);
      #1;
      chk("tie2_idle_ack0", ack0, 1'b0);
      chk("tie2_idle_ack1", ack1, 1'b0);
      @(negedge Clk);
      #1;
`ifdef DMEM_ARB_RR_EN
      chk("tie2_ack1", ack1, 1'b1);
      chk("tie2_ack0", ack0, 1'b0);
      chk("tie2_addr", mem_addr, 64'h20);
      chk("tie2_stall0", stall0, 1'b1);
`else
      chk("tie2_ack0", ack0, 1'b1);
      chk("tie2_ack1", ack1, 1'b0);
      chk("tie2_addr", mem_addr, 64'h10);
      chk("tie2_stall0", stall0, 1'b0);
`endif
      req0 = 1'b0; req1 = 1'b0;
      @(negedge Clk);
      #1;
      chk("tie_done_addr", mem_addr, 64'h0);
      @(negedge Clk);

      // Locked burst limited to 4 while the core waits
      req1 = 1'b1; we1 = 1'b0; addr1 = 64'h20; lock1 = 1'b1;
      #1;
      chk("bst_ack1_early", ack1, 1'b0);
      @(negedge Clk);
      for (int i = 0; i < 4; i++) begin
         req0 = 1'b1; we0 = 1'b0; addr0 = 64'h10;
         #1;
         chk("bst_ack1", ack1, 1'b1);
         chk("bst_rdata1", rdata1, 64'h55);
         chk("bst_ack0", ack0, 1'b0);
         chk("bst_stall0", stall0, 1'b1);
         @(negedge Clk);
      end
      #1;
      chk("bst_end_ack1", ack1, 1'b0);
      chk("bst_end_ack0", ack0, 1'b0);
      chk("bst_end_stall0", stall0, 1'b1);
      chk("bst_end_addr", mem_addr, 64'h0);
      @(negedge Clk);
      #1;
      chk("bst_core_ack0", ack0, 1'b1);
      chk("bst_core_ack1", ack1, 1'b0);
      chk("bst_core_stall0", stall0, 1'b0);
      chk("bst_core_rdata0", rdata0, 64'hDEAD);
      req0 = 1'b0; req1 = 1'b0; lock1 = 1'b0;
      @(negedge Clk);
      #1;
      chk("bst_idle_addr", mem_addr, 64'h0);
      @(negedge Clk);

      // Reset during a loader write to 0x30 must not commit
      req1 = 1'b1; we1 = 1'b1; addr1 = 64'h30; wdata1 = 64'h99;
      #1;
      chk("rw_ack1_early", ack1, 1'b0);
      @(negedge Clk);
      reset = 1'b1;
      #1;
      chk("rw_memwrite", mem_MemWrite, 1'b0);
      chk("rw_ack1", ack1, 1'b0);
      @(negedge Clk);
      reset = 1'b0; req1 = 1'b0;
      #1;
      chk("rw_idle_addr", mem_addr, 64'h0);
      chk("rw_mem30", mem[8'h30], 64'h77);
      req0 = 1'b1; we0 = 1'b0; addr0 = 64'h30;
      @(negedge Clk);
      #1;
      chk("rw_rb_ack0", ack0, 1'b1);
      chk("rw_rb_rdata0", rdata0, 64'h77);
      req0 = 1'b0;
      @(negedge Clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single data memory between the core's load/store path (port 0) and a loader/debug requester (port 1, used for program load and memory inspection). It sits between the core datapath (ALU result as address, rs2 value as write data, MemRead/MemWrite) and the data memory. It sequences every access through a small grant FSM, supports locked bursts on port 1, and produces a stall for the core's PC while port 0 waits.

## Interface
Parameters:
- ADDR_W, 64, address width
- DATA_W, 64, data width
- MAX_BURST, 8, maximum consecutive SERVE1 cycles per locked tenure (≥1)

Ports (clock and reset first):
- Clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- req0  in  1  core request, held high until ack0
- we0  in  1  core write (1) / read (0)
- addr0  in  ADDR_W  core address
- wdata0  in  DATA_W  core write data
- ack0  out  1  one-cycle completion pulse for core
- rdata0  out  DATA_W  core read data, valid when ack0 & ~we0
- stall0  out  1  req0 & ~ack0, freezes core PC
- req1, we1, addr1, wdata1, ack1, rdata1: same as port 0 for loader
- lock1  in  1  loader requests to hold grant across cycles
- mem_addr  out  ADDR_W  to data memory address
- mem_wdata  out  DATA_W  to data memory write data
- mem_MemWrite  out  1  memory write strobe
- mem_MemRead  out  1  memory read strobe
- mem_rdata  in  DATA_W  memory read data (combinational read)

## Operation
- FSM states: IDLE, SERVE0, SERVE1. Registered: state, burst_cnt (clog2(MAX_BURST)+1 bits), last (index of last served port).
- IDLE: no requests → stay. Requests present → picker selects a winner, next state SERVE_winner, last ← winner.
- SERVE_x: mem_addr/mem_wdata from port x; strobe mem_MemWrite=we_x or mem_MemRead=~we_x only if req_x; ack_x=req_x.
- SERVE0 → IDLE always.
- SERVE1: burst_cnt increments. Stay SERVE1 if lock1 high and burst_cnt+1 < MAX_BURST; else → IDLE, burst_cnt ← 0. Cycles in SERVE1 with req1 low issue no strobes and no ack, but still count toward the tenure.
- rdata_x = mem_rdata when ack_x & ~we_x, else 0.
- Non-granted port: ack 0, no influence on memory outputs. In IDLE, mem_addr/mem_wdata = 0.
- Tie rule (IDLE with req0 & req1): governed by Configuration.
- Writes commit at the rising edge ending the ack cycle.

## Timing
- Latency: req_x first high in cycle N (state IDLE) → ack_x in cycle N+1. Core stalls exactly one cycle per uncontended access.
- Max throughput: port 0 one access per 2 cycles; port 1 locked one per cycle.
- Requester may change addr/we/wdata or drop req only after seeing ack; changes before ack are undefined.
- Reset: state IDLE, burst_cnt 0, last = 1 (port 0 wins first tie). While reset is high, ack0, ack1, mem_MemWrite, mem_MemRead, rdata0 and rdata1 are forced to 0 combinationally. No write commits at a reset edge, even if reset arrives mid-SERVE or mid-burst.
- lock1 dropped mid-burst: the current SERVE1 cycle completes, then → IDLE.
- Burst limit reached while req0 pending: → IDLE, and port 0 is served next only per the tie rule.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin. On a tie the port ≠ last wins. Neither port is starved.
- Not defined: fixed priority. Port 0 always wins ties. Port 1 may starve under continuous core traffic. `last` is still maintained but ignored.

## Structure
- Package dmem_arb_pkg holds:
  - state encoding ST_IDLE=2'd0, ST_SERVE0=2'd1, ST_SERVE1=2'd2
  - port indices PORT_CORE=1'b0, PORT_LDR=1'b1
- Sub-module arb_pick: combinational 2-input picker taking (req0, req1, last) and producing (valid, winner). It contains the DMEM_ARB_RR_EN switch.

## Test plan
- Reset held 3 cycles with req0/req1 high → all outputs 0 throughout; first cycle after release is IDLE.
- Core write addr0=0x10, wdata0=0xDEAD in cycle 1 → stall0=1 in cycle 1; cycle 2 ack0=1, mem_MemWrite=1, mem_addr=0x10; later read of 0x10 returns 0xDEAD.
- Preload mem[0x20]=0x55; port 1 read 0x20 → rdata1=0x55 in its ack cycle, rdata0=0.
- Tie after reset → port 0 served. Second tie → port 1 with DMEM_ARB_RR_EN, port 0 without.
- MAX_BURST=4, lock1 and req1 held, req0 high → exactly 4 consecutive ack1, then IDLE, then ack0; stall0 high the whole time before ack0.
- reset asserted during a SERVE1 write to 0x30 → mem_MemWrite=0 that cycle; mem[0x30] unchanged; state IDLE next cycle.
